// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard-controller state encoding and the
// hardwired zero-register index.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

    // Register $0 is hardwired to zero, so it never carries a real dependency.
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard terms for the pipeline controller.
// Ports:
//   ifid_rs, ifid_rt, ifid_usesRt : source operands of the instruction in IF/ID
//   idex_memR, idex_gprDes        : load flag and destination of the instruction in ID/EX
//   exmem_pcSel, exmem_zero       : branch select and ALU zero from EX/MEM
//   loadUse                       : IF/ID consumes the result of a load still in ID/EX
//   taken                         : branch in EX/MEM resolves taken
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_usesRt,
    input  logic             idex_memR,
    input  logic [REG_W-1:0] idex_gprDes,
    input  logic             exmem_pcSel,
    input  logic             exmem_zero,
    output logic             loadUse,
    output logic             taken
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (idex_gprDes == ifid_rs);
    assign rt_match = ifid_usesRt & (idex_gprDes == ifid_rt);
    assign loadUse  = idex_memR & (idex_gprDes != ZERO_REG) & (rs_match | rt_match);
    assign taken    = exmem_pcSel & exmem_zero;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait freezing with a timeout into a sticky error state.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   ifid_*, idex_*, exmem_*      : hazard sources from the pipeline registers
//   mem_req, mem_ready           : data-memory handshake from the MEM stage
//   pcWrite..memwbWrite          : pipeline register write enables (combinational)
//   ifidFlush..exmemFlush        : pipeline register flushes (combinational)
//   memErr                       : sticky memory-timeout error
//   stallCnt, flushCnt           : saturating event counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_usesRt,
    input  logic             idex_memR,
    input  logic [REG_W-1:0] idex_gprDes,
    input  logic             exmem_pcSel,
    input  logic             exmem_zero,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             idexWrite,
    output logic             exmemWrite,
    output logic             memwbWrite,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             exmemFlush,
    output logic             memErr,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              taken;
    logic              mem_busy;
    logic              run_like;
    logic              busy_eff;
    logic              stall_inc;
    logic              flush_inc;

    hazard_detect u_hazard_detect (
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .ifid_usesRt (ifid_usesRt),
        .idex_memR   (idex_memR),
        .idex_gprDes (idex_gprDes),
        .exmem_pcSel (exmem_pcSel),
        .exmem_zero  (exmem_zero),
        .loadUse     (load_use),
        .taken       (taken)
    );

    assign mem_busy = mem_req & ~mem_ready;

    // Write/flush decode; MEM_WAIT with ready behaves like RUN without memory stall.
    always_comb begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexWrite  = 1'b0;
        exmemWrite = 1'b0;
        memwbWrite = 1'b0;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        exmemFlush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        run_like   = 1'b0;
        busy_eff   = 1'b0;

        case (state)
            RUN: begin
                run_like = 1'b1;
                busy_eff = mem_busy;
            end
            MEM_WAIT: begin
                if (mem_ready) run_like  = 1'b1;
                else           stall_inc = 1'b1;
            end
            default: ;
        endcase

        if (run_like && !busy_eff) begin
            pcWrite    = 1'b1;
            ifidWrite  = 1'b1;
            idexWrite  = 1'b1;
            exmemWrite = 1'b1;
            memwbWrite = 1'b1;
            if (taken) begin
                ifidFlush  = 1'b1;
                idexFlush  = 1'b1;
                exmemFlush = 1'b1;
                flush_inc  = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID, inject one bubble into ID/EX.
                pcWrite   = 1'b0;
                ifidWrite = 1'b0;
                idexFlush = 1'b1;
                stall_inc = 1'b1;
            end
        end

        if (rst) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbWrite = 1'b0;
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
            exmemFlush = 1'b1;
            stall_inc  = 1'b0;
            flush_inc  = 1'b0;
        end
    end

    // State, wait timer, sticky error and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            memErr   <= 1'b0;
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stall_inc && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
            if (flush_inc && (flushCnt != '1)) flushCnt <= flushCnt + CNT_W'(1);

            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                        state  <= ERROR;
                        memErr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERROR: memErr <= 1'b1;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance (dut_a) and a
// TIMEOUT=4 / CNT_W=4 instance (dut_s) share the same stimulus.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] ifid_rs, ifid_rt, idex_gprDes;
    logic       ifid_usesRt, idex_memR, exmem_pcSel, exmem_zero, mem_req, mem_ready;

    logic        pcw_a, ifw_a, idw_a, exw_a, mww_a, iff_a, idf_a, exf_a, err_a;
    logic [15:0] stall_a, flush_a;
    logic        pcw_s, ifw_s, idw_s, exw_s, mww_s, iff_s, idf_s, exf_s, err_s;
    logic [3:0]  stall_s, flush_s;

    logic [4:0] wr_a, wr_s;
    logic [2:0] fl_a, fl_s;
    assign wr_a = {pcw_a, ifw_a, idw_a, exw_a, mww_a};
    assign wr_s = {pcw_s, ifw_s, idw_s, exw_s, mww_s};
    assign fl_a = {iff_a, idf_a, exf_a};
    assign fl_s = {iff_s, idf_s, exf_s};

    int checks;
    int failures;

    pipe_hazard_ctrl dut_a (
        .clk(clk), .rst(rst),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_usesRt(ifid_usesRt),
        .idex_memR(idex_memR), .idex_gprDes(idex_gprDes),
        .exmem_pcSel(exmem_pcSel), .exmem_zero(exmem_zero),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pcWrite(pcw_a), .ifidWrite(ifw_a), .idexWrite(idw_a),
        .exmemWrite(exw_a), .memwbWrite(mww_a),
        .ifidFlush(iff_a), .idexFlush(idf_a), .exmemFlush(exf_a),
        .memErr(err_a), .stallCnt(stall_a), .flushCnt(flush_a)
    );

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_usesRt(ifid_usesRt),
        .idex_memR(idex_memR), .idex_gprDes(idex_gprDes),
        .exmem_pcSel(exmem_pcSel), .exmem_zero(exmem_zero),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pcWrite(pcw_s), .ifidWrite(ifw_s), .idexWrite(idw_s),
        .exmemWrite(exw_s), .memwbWrite(mww_s),
        .ifidFlush(iff_s), .idexFlush(idf_s), .exmemFlush(exf_s),
        .memErr(err_s), .stallCnt(stall_s), .flushCnt(flush_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_gprDes = 5'd0;
        ifid_usesRt = 1'b0; idex_memR = 1'b0;
        exmem_pcSel = 1'b0; exmem_zero = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;

        // Reset forces flush and blocks all writes.
        @(negedge clk); #1;
        chk("rst_writes", 32'(wr_a), 32'h00);
        chk("rst_flush", 32'(fl_a), 32'h7);

        @(negedge clk); rst = 1'b0; #1;
        chk("idle_writes", 32'(wr_a), 32'h1F);
        chk("idle_flush", 32'(fl_a), 32'h0);
        chk("idle_stallcnt", 32'(stall_a), 32'd0);
        chk("idle_flushcnt", 32'(flush_a), 32'd0);
        chk("idle_memerr", 32'(err_a), 32'd0);

        // lw $8 in ID/EX, IF/ID reads rs=$8: one bubble.
        @(negedge clk); idex_memR = 1'b1; idex_gprDes = 5'd8; ifid_rs = 5'd8; #1;
        chk("lu_rs_writes", 32'(wr_a), 32'h07);
        chk("lu_rs_flush", 32'(fl_a), 32'h2);
        @(negedge clk); idex_memR = 1'b0; #1;
        chk("lu_after_writes", 32'(wr_a), 32'h1F);
        chk("lu_after_stallcnt", 32'(stall_a), 32'd1);

        // Load to $0 never stalls.
        @(negedge clk); idex_memR = 1'b1; idex_gprDes = 5'd0; ifid_rs = 5'd0;
        ifid_rt = 5'd0; ifid_usesRt = 1'b1; #1;
        chk("zero_writes", 32'(wr_a), 32'h1F);
        chk("zero_flush", 32'(fl_a), 32'h0);

        // rt match only counts when the instruction reads rt.
        @(negedge clk); idex_gprDes = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9; ifid_usesRt = 1'b0; #1;
        chk("rt_unused_writes", 32'(wr_a), 32'h1F);
        chk("zero_stallcnt", 32'(stall_a), 32'd1);
        @(negedge clk); ifid_usesRt = 1'b1; #1;
        chk("rt_used_writes", 32'(wr_a), 32'h07);
        @(negedge clk); idex_memR = 1'b0; #1;
        chk("rt_stallcnt", 32'(stall_a), 32'd2);

        // Taken branch wins over load-use.
        @(negedge clk); exmem_pcSel = 1'b1; exmem_zero = 1'b1; idex_memR = 1'b1;
        idex_gprDes = 5'd8; ifid_rs = 5'd8; ifid_usesRt = 1'b0; #1;
        chk("br_writes", 32'(wr_a), 32'h1F);
        chk("br_flush", 32'(fl_a), 32'h7);
        @(negedge clk); exmem_zero = 1'b0; idex_memR = 1'b0; #1;
        chk("br_nt_flush", 32'(fl_a), 32'h0);
        chk("br_stallcnt", 32'(stall_a), 32'd2);
        chk("br_flushcnt", 32'(flush_a), 32'd1);
        exmem_pcSel = 1'b0;

        // Memory wait: entry cycle plus 3 waits frozen, release on ready.
        @(negedge clk); mem_req = 1'b1; mem_ready = 1'b0; #1;
        chk("mw_entry_writes", 32'(wr_a), 32'h00);
        chk("mw_entry_flush", 32'(fl_a), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("mw_wait_writes", 32'(wr_a), 32'h00);
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("mw_release_writes", 32'(wr_a), 32'h1F);
        chk("mw_release_flush", 32'(fl_a), 32'h0);
        chk("mw_stallcnt", 32'(stall_a), 32'd5);
        chk("mw_s_memerr", 32'(err_s), 32'd0);
        @(negedge clk); mem_req = 1'b0; mem_ready = 1'b0; #1;
        chk("mw_run_writes", 32'(wr_a), 32'h1F);
        chk("mw_run_stallcnt", 32'(stall_a), 32'd5);

        // Timeout on the TIMEOUT=4 instance.
        @(negedge clk); mem_req = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("to_before_memerr", 32'(err_s), 32'd0);
        @(negedge clk); #1;
        chk("to_memerr", 32'(err_s), 32'd1);
        chk("to_writes", 32'(wr_s), 32'h00);
        chk("to_flush", 32'(fl_s), 32'h0);
        chk("to_a_memerr", 32'(err_a), 32'd0);
        @(negedge clk); mem_req = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("err_sticky", 32'(err_s), 32'd1);
        chk("err_writes", 32'(wr_s), 32'h00);
        chk("err_a_writes", 32'(wr_a), 32'h1F);

        // Reset from ERROR (dut_s) and mid-MEM_WAIT (dut_a).
        @(negedge clk); mem_req = 1'b1; mem_ready = 1'b0;
        @(negedge clk); rst = 1'b1; mem_req = 1'b0; #1;
        chk("rst2_flush", 32'(fl_s), 32'h7);
        chk("rst2_writes", 32'(wr_a), 32'h00);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst2_memerr", 32'(err_s), 32'd0);
        chk("rst2_s_writes", 32'(wr_s), 32'h1F);
        chk("rst2_a_writes", 32'(wr_a), 32'h1F);
        chk("rst2_stallcnt", 32'(stall_a), 32'd0);
        chk("rst2_flushcnt", 32'(flush_a), 32'd0);

        // 20 load-use stalls saturate the 4-bit counter at 15.
        @(negedge clk); idex_memR = 1'b1; idex_gprDes = 5'd8; ifid_rs = 5'd8;
        repeat (20) @(negedge clk);
        #1;
        chk("sat_s_stallcnt", 32'(stall_s), 32'd15);
        chk("sat_a_stallcnt", 32'(stall_a), 32'd20);
        chk("sat_s_writes", 32'(wr_s), 32'h07);
        idex_memR = 1'b0;
        @(negedge clk); #1;
        chk("sat_hold_s", 32'(stall_s), 32'd15);
        chk("sat_hold_a", 32'(stall_a), 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
